// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch / load-store) in front of a single fixed-latency memory port.
// Data has priority; a streak counter forces a fetch grant after MAX_D_STREAK data grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     streak;
    logic [3:0]        lat_cnt;
    logic              own_d;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              arb;
    logic              any_req;
    logic              pick_d;

    always_comb begin
        arb       = (state == IDLE) || (state == RESP);
        any_req   = if_req || d_req;
        pick_d    = d_req && !(if_req && (streak == SW'(MAX_D_STREAK)));
        state_nxt = state;
        unique case (state)
            IDLE, RESP: state_nxt = any_req ? ACCESS : IDLE;
            ACCESS:     state_nxt = WAIT;
            WAIT:       if (lat_cnt == '0) state_nxt = RESP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            own_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            streak    <= '0;
            lat_cnt   <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (arb && any_req) begin
                own_d     <= pick_d;
                lat_we    <= pick_d && d_we;
                lat_addr  <= pick_d ? d_addr : if_addr;
                lat_wdata <= pick_d ? d_wdata : '0;
            end
            // Only a data grant that made a waiting fetch lose extends the streak.
            if (arb) begin
                if (!if_req || !pick_d)
                    streak <= '0;
                else if (streak != SW'(MAX_D_STREAK))
                    streak <= streak + SW'(1);
            end
            if (state == ACCESS)
                lat_cnt <= 4'(READ_LATENCY - 1);
            else if (state == WAIT && lat_cnt != '0)
                lat_cnt <= lat_cnt - 4'd1;
            if (state == WAIT && lat_cnt == '0 && !lat_we) begin
                if (own_d) d_rdata  <= mem_rdata;
                else       if_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en && lat_we;
    assign mem_addr  = mem_en ? lat_addr : '0;
    assign mem_wdata = mem_en ? lat_wdata : '0;
    assign if_gnt    = mem_en && !own_d;
    assign d_gnt     = mem_en && own_d;
    assign if_rvalid = (state == RESP) && !own_d;
    assign d_rvalid  = (state == RESP) && own_d;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one default instance (latency 1) with a small
// read model, and a READ_LATENCY=3 instance whose mem_rdata is driven cycle by cycle.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;

    logic        if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
    logic        mem_en, mem_we, busy;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    always #5 clock = ~clock;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.READ_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_2000: return 32'hDEAD_BEEF;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // One-cycle read latency memory; returns a poison word on non-read cycles.
    always @(posedge clock)
        mem_rdata <= (mem_en && !mem_we) ? mem_lookup(mem_addr) : 32'hBAD0_BAD0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== 4'b0) begin errors++; $display("FAIL rst_hs: got %b want 0000", {if_gnt, d_gnt, if_rvalid, d_rvalid}); end
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 66'b0) begin errors++; $display("FAIL rst_mem: got %h want 0", {mem_en, mem_we, mem_addr, mem_wdata}); end
        checks++; if ({if_rdata, d_rdata} !== 64'b0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, d_rdata}); end
        checks++; if ({b_busy, b_mem_en, b_d_rdata} !== 34'b0) begin errors++; $display("FAIL rst_dut3: got %h want 0", {b_busy, b_mem_en, b_d_rdata}); end
    endtask

    task automatic test_fetch_alone();
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        checks++; if ({if_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL fa_gnt: got %b want 10", {if_gnt, d_gnt}); end
        checks++; if ({mem_en, mem_we} !== 2'b10) begin errors++; $display("FAIL fa_en: got %b want 10", {mem_en, mem_we}); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL fa_addr: got %h want 00000100", mem_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fa_busy1: got %b want 1", busy); end
        tick();
        if_req = 1'b0;
        checks++; if ({busy, mem_en, if_gnt, if_rvalid} !== 4'b1000) begin errors++; $display("FAIL fa_wait: got %b want 1000", {busy, mem_en, if_gnt, if_rvalid}); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL fa_addr_idle: got %h want 0", mem_addr); end
        tick();
        checks++; if ({busy, if_rvalid, d_rvalid} !== 3'b110) begin errors++; $display("FAIL fa_resp: got %b want 110", {busy, if_rvalid, d_rvalid}); end
        checks++; if (if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fa_rdata: got %h want 00500093", if_rdata); end
        tick();
        checks++; if ({busy, if_rvalid} !== 2'b00) begin errors++; $display("FAIL fa_idle: got %b want 00", {busy, if_rvalid}); end
    endtask

    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        tick();
        checks++; if ({d_gnt, if_gnt} !== 2'b10) begin errors++; $display("FAIL sim_gnt1: got %b want 10", {d_gnt, if_gnt}); end
        checks++; if (mem_addr !== 32'h2000) begin errors++; $display("FAIL sim_addr1: got %h want 00002000", mem_addr); end
        tick();
        d_req = 1'b0;
        tick();
        checks++; if ({d_rvalid, if_rvalid, if_gnt} !== 3'b100) begin errors++; $display("FAIL sim_resp1: got %b want 100", {d_rvalid, if_rvalid, if_gnt}); end
        checks++; if (d_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sim_drdata: got %h want deadbeef", d_rdata); end
        checks++; if (if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL sim_ifhold: got %h want 00500093", if_rdata); end
        tick();
        checks++; if ({busy, if_gnt, d_gnt} !== 3'b110) begin errors++; $display("FAIL sim_gnt2: got %b want 110", {busy, if_gnt, d_gnt}); end
        checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL sim_addr2: got %h want 00000104", mem_addr); end
        tick();
        if_req = 1'b0;
        checks++; if (if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL sim_ifhold2: got %h want 00500093", if_rdata); end
        tick();
        checks++; if ({if_rvalid, d_rvalid} !== 2'b10) begin errors++; $display("FAIL sim_resp2: got %b want 10", {if_rvalid, d_rvalid}); end
        checks++; if (if_rdata !== 32'hA5A5_0104) begin errors++; $display("FAIL sim_ifrdata: got %h want a5a50104", if_rdata); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sim_idle: got %b want 0", busy); end
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hCAFE_F00D;
        tick();
        checks++; if ({mem_en, mem_we, d_gnt} !== 3'b111) begin errors++; $display("FAIL st_en: got %b want 111", {mem_en, mem_we, d_gnt}); end
        checks++; if ({mem_addr, mem_wdata} !== {32'h2004, 32'hCAFE_F00D}) begin errors++; $display("FAIL st_bus: got %h want 00002004cafef00d", {mem_addr, mem_wdata}); end
        tick();
        d_req = 1'b0; d_we = 1'b0;
        checks++; if ({mem_en, mem_we, mem_wdata} !== 34'b0) begin errors++; $display("FAIL st_off: got %h want 0", {mem_en, mem_we, mem_wdata}); end
        tick();
        checks++; if ({d_rvalid, if_rvalid} !== 2'b10) begin errors++; $display("FAIL st_ack: got %b want 10", {d_rvalid, if_rvalid}); end
        checks++; if (d_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_dhold: got %h want deadbeef", d_rdata); end
        tick();
        checks++; if ({busy, d_rvalid} !== 2'b00) begin errors++; $display("FAIL st_idle: got %b want 00", {busy, d_rvalid}); end
    endtask

    task automatic test_streak();
        logic [9:0] order;
        int n = 0;
        int clash = 0;
        order = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 0; c < 60 && n < 10; c++) begin
            tick();
            if ((if_gnt && d_gnt) || (if_rvalid && d_rvalid) || (if_gnt && if_rvalid) || (d_gnt && d_rvalid)) clash++;
            if (d_gnt) begin order[9 - n] = 1'b1; n++; end
            else if (if_gnt) begin order[9 - n] = 1'b0; n++; end
        end
        d_req = 1'b0; if_req = 1'b0;
        checks++; if (n !== 10) begin errors++; $display("FAIL sk_count: got %0d grants want 10", n); end
        checks++; if (order !== 10'b1111011110) begin errors++; $display("FAIL sk_order: got %b want 1111011110 (1=D)", order); end
        for (int c = 0; c < 20 && busy; c++) begin
            tick();
            if ((if_gnt && d_gnt) || (if_rvalid && d_rvalid)) clash++;
        end
        checks++; if (clash !== 0) begin errors++; $display("FAIL sk_excl: got %0d clashes want 0", clash); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sk_drain: got busy %b want 0", busy); end
    endtask

    task automatic test_latency3();
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h3000;
        tick();
        checks++; if ({b_d_gnt, b_mem_en} !== 2'b11) begin errors++; $display("FAIL l3_gnt: got %b want 11", {b_d_gnt, b_mem_en}); end
        checks++; if (b_mem_addr !== 32'h3000) begin errors++; $display("FAIL l3_addr: got %h want 00003000", b_mem_addr); end
        b_mem_rdata = 32'h1111_1111;
        tick();
        b_d_req = 1'b0;
        checks++; if ({b_busy, b_d_rvalid} !== 2'b10) begin errors++; $display("FAIL l3_w1: got %b want 10", {b_busy, b_d_rvalid}); end
        b_mem_rdata = 32'h2222_2222;
        tick();
        checks++; if ({b_busy, b_d_rvalid} !== 2'b10) begin errors++; $display("FAIL l3_w2: got %b want 10", {b_busy, b_d_rvalid}); end
        b_mem_rdata = 32'h3333_3333;
        tick();
        checks++; if ({b_busy, b_d_rvalid} !== 2'b10) begin errors++; $display("FAIL l3_w3: got %b want 10", {b_busy, b_d_rvalid}); end
        checks++; if (b_d_rdata !== 32'h0) begin errors++; $display("FAIL l3_early: got %h want 0", b_d_rdata); end
        b_mem_rdata = 32'h1234_5678;
        tick();
        b_mem_rdata = 32'h5555_5555;
        checks++; if (b_d_rvalid !== 1'b1) begin errors++; $display("FAIL l3_rvalid: got %b want 1", b_d_rvalid); end
        checks++; if (b_d_rdata !== 32'h1234_5678) begin errors++; $display("FAIL l3_rdata: got %h want 12345678", b_d_rdata); end
        tick();
        checks++; if ({b_busy, b_d_rvalid} !== 2'b00) begin errors++; $display("FAIL l3_idle: got %b want 00", {b_busy, b_d_rvalid}); end
        checks++; if (b_d_rdata !== 32'h1234_5678) begin errors++; $display("FAIL l3_hold: got %h want 12345678", b_d_rdata); end
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1; if_addr = 32'h108;
        tick();
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b want 1", if_gnt); end
        tick();
        if_req = 1'b0;
        reset = 1'b1;
        tick();
        checks++; if ({busy, if_rvalid, d_rvalid, mem_en, if_gnt, d_gnt} !== 6'b0) begin errors++; $display("FAIL rm_state: got %b want 000000", {busy, if_rvalid, d_rvalid, mem_en, if_gnt, d_gnt}); end
        checks++; if ({if_rdata, d_rdata, mem_addr} !== 96'b0) begin errors++; $display("FAIL rm_data: got %h want 0", {if_rdata, d_rdata, mem_addr}); end
        reset = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        tick();
        checks++; if ({d_gnt, if_rvalid} !== 2'b10) begin errors++; $display("FAIL rm_regnt: got %b want 10", {d_gnt, if_rvalid}); end
        tick();
        d_req = 1'b0;
        tick();
        checks++; if ({d_rvalid, if_rvalid} !== 2'b10) begin errors++; $display("FAIL rm_resp: got %b want 10", {d_rvalid, if_rvalid}); end
        checks++; if (d_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rm_rdata: got %h want deadbeef", d_rdata); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle: got %b want 0", busy); end
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
        b_mem_rdata = '0;
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_fetch_alone();
        test_simultaneous();
        test_store();
        test_streak();
        test_latency3();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch path and the load/store data path.
- Serialises accesses through a fixed-latency memory port and returns per-requester responses.
- Gives data accesses priority, with a starvation guard for fetch.
- Exposes a busy flag so the datapath can stall the PC and register writeback while an access is outstanding.

Parameters:
ADDR_W, 32, address width of requesters and memory port
DATA_W, 32, data width
READ_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..15
MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits; legal range ≥1

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_W  fetch address, stable while if_req is high
if_gnt  out  1  one-cycle grant pulse to fetch
if_rvalid  out  1  one-cycle fetch response pulse
if_rdata  out  DATA_W  fetched word, registered
d_req  in  1  data request, held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle grant pulse to data
d_rvalid  out  1  one-cycle load-data / store-complete pulse
d_rdata  out  DATA_W  load data, registered
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable, valid with mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid READ_LATENCY cycles after the mem_en cycle
busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`.
- Reset values: state = IDLE; all outputs 0, including if_rdata, d_rdata and the mem_* outputs; streak counter 0; latency counter 0.
- Reset mid-transaction: the access is abandoned and no rvalid is issued. mem_en is low from the cycle after the reset edge.
- FSM states and transitions:
  - IDLE: arbitrate. If any req is high, latch the winner (owner, addr, we, wdata) and go to ACCESS at the next edge; otherwise stay in IDLE.
  - ACCESS (1 cycle):
    - mem_en = 1; mem_we, mem_addr and mem_wdata driven from the latched values.
    - Owner's gnt = 1 in this cycle.
    - Load latency counter with READ_LATENCY−1, then go to WAIT.
  - WAIT (READ_LATENCY cycles):
    - If counter = 0: capture mem_rdata into the owner's rdata register (reads only) and go to RESP.
    - Otherwise decrement the counter.
  - RESP (1 cycle):
    - Owner's rvalid = 1.
    - Arbitrate as in IDLE: any req → ACCESS (back-to-back, no idle bubble); none → IDLE.
- Requests: req is ignored in ACCESS and WAIT. A requester drops req the cycle after its gnt; a req still high in RESP or IDLE is treated as a new request.
- Timing: req first seen in cycle 0 → gnt in cycle 1 → rvalid in cycle READ_LATENCY+2. Sustained throughput is one access per READ_LATENCY+2 cycles.
- Stores: follow the same sequence. d_rvalid pulses as the completion ack; d_rdata keeps its previous value.
- rdata registers are updated only for the owning requester's reads and hold their value otherwise.
- mem_we, mem_addr and mem_wdata are 0 whenever mem_en = 0.
- Arbitration: data wins by default. Fetch wins if if_req = 1 and streak = MAX_D_STREAK.
- Streak counter:
  - Data grant with if_req high at arbitration → increment (saturating).
  - Fetch grant, or arbitration with if_req low → clear to 0.
- Simultaneous requests are resolved by the rule above. At most one gnt and one rvalid are high per cycle, and gnt and rvalid never go to the same requester in the same cycle.
- Addresses and data are passed through unmodified; alignment is the requester's responsibility.

Test Plan:
- Fetch alone, READ_LATENCY=1, if_addr=0x100, mem returns 0x00500093 → if_gnt in cycle 1, mem_en/mem_addr=0x100 in cycle 1, if_rvalid with if_rdata=0x00500093 in cycle 3, busy high cycles 1–3.
- Simultaneous if_req and d_req (load 0x2000 → 0xDEADBEEF) → d_gnt first, d_rvalid with 0xDEADBEEF; fetch granted in that same RESP cycle's arbitration with no IDLE between, if_rdata unchanged until its own response.
- Store d_we=1, d_addr=0x2004, d_wdata=0xCAFEF00D → one cycle with mem_en=1, mem_we=1, mem_addr=0x2004, mem_wdata=0xCAFEF00D; d_rvalid pulse; d_rdata unchanged.
- MAX_D_STREAK=4, d_req and if_req held continuously → grant order D,D,D,D,F,D,D,D,D,F; if_gnt never delayed beyond 4 data accesses.
- READ_LATENCY=3, load → exactly 3 WAIT cycles; rvalid in cycle 5; mem_rdata changing outside the capture cycle does not affect d_rdata.
- reset asserted in the WAIT cycle → next cycle state IDLE, busy=0, no rvalid, all outputs 0; a request pending after reset is granted normally.
